// File: rtl/wino_tile_fetch_if.sv
// Handshake and bus bundle for the Winograd input-tile fetch sequencer.
// The master side is the sequencer: it takes run control and downstream
// ready, and drives the two memory read ports plus the return-path tags.
interface wino_tile_fetch_if #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
);
    // run control
    logic              start;
    logic [ADDR_W-1:0] cfg_base_addr;
    logic [CNT_W-1:0]  cfg_num_tiles;
    logic              scan_enable;
    logic              busy;
    logic              done;

    // downstream throttle
    logic              tile_ready_in;

    // dual-port memory read requests
    logic [ADDR_W-1:0] addr_1_out;
    logic [ADDR_W-1:0] addr_2_out;
    logic              addr_1_valid_out;
    logic              addr_2_valid_out;

    // tags aligned with the returning data pair
    logic              pair_valid_out;
    logic              phase_out;
    logic              tile_last_out;

    modport master (
        input  start, cfg_base_addr, cfg_num_tiles, scan_enable, tile_ready_in,
        output busy, done,
        output addr_1_out, addr_2_out, addr_1_valid_out, addr_2_valid_out,
        output pair_valid_out, phase_out, tile_last_out
    );

    modport slave (
        output start, cfg_base_addr, cfg_num_tiles, scan_enable, tile_ready_in,
        input  busy, done,
        input  addr_1_out, addr_2_out, addr_1_valid_out, addr_2_valid_out,
        input  pair_valid_out, phase_out, tile_last_out
    );
endinterface

// File: rtl/wino_tile_fetch_ctrl.sv
// Read sequencer for the dual-port input data memory of the Winograd
// F(2x2,3x3) datapath. Each 4-row tile is read as two row pairs on
// consecutive issue cycles (rows r,r+1 then r+2,r+3); consecutive tiles
// overlap by advancing the row pointer by ROW_STEP. Returning data is
// tagged one cycle after issue to match the memory read latency.
module wino_tile_fetch_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int CNT_W    = 8,
    parameter int ROW_STEP = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    wino_tile_fetch_if.master    bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH_A = 2'd1,
        FETCH_B = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] row_ptr_q, row_ptr_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [ADDR_W-1:0] addr_1_q, addr_1_d;
    logic [ADDR_W-1:0] addr_2_q, addr_2_d;
    logic              pair_valid_q, pair_valid_d;
    logic              phase_q, phase_d;
    logic              tile_last_q, tile_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              fetching;
    logic              issue;

    // A read goes out only from a fetch state with the consumer ready and no
    // scan load in progress; scan_enable always wins over ready.
    assign fetching = (state_q == FETCH_A) || (state_q == FETCH_B);
    assign issue    = fetching && bus.tile_ready_in && !bus.scan_enable;

    assign bus.addr_1_valid_out = issue;
    assign bus.addr_2_valid_out = issue;
    assign bus.addr_1_out       = addr_1_q;
    assign bus.addr_2_out       = addr_2_q;
    assign bus.pair_valid_out   = pair_valid_q;
    assign bus.phase_out        = phase_q;
    assign bus.tile_last_out    = tile_last_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;

    // Next-state logic. The address registers always hold the pair that the
    // next issue will use, so they are stable while stalled and already
    // correct in the cycle the combinational valids rise.
    always_comb begin
        state_d      = state_q;
        row_ptr_d    = row_ptr_q;
        remaining_d  = remaining_q;
        addr_1_d     = addr_1_q;
        addr_2_d     = addr_2_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pair_valid_d = issue;
        phase_d      = issue && (state_q == FETCH_B);
        tile_last_d  = issue && (state_q == FETCH_B) && (remaining_q == CNT_W'(1));

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.scan_enable) begin
                    row_ptr_d   = bus.cfg_base_addr;
                    remaining_d = bus.cfg_num_tiles;
                    addr_1_d    = bus.cfg_base_addr;
                    addr_2_d    = bus.cfg_base_addr + ADDR_W'(1);
                    busy_d      = 1'b1;
                    state_d     = (bus.cfg_num_tiles == '0) ? DRAIN : FETCH_A;
                end
            end
            FETCH_A: begin
                if (bus.scan_enable) begin
                    state_d = DRAIN;
                end else if (bus.tile_ready_in) begin
                    addr_1_d = row_ptr_q + ADDR_W'(2);
                    addr_2_d = row_ptr_q + ADDR_W'(3);
                    state_d  = FETCH_B;
                end
            end
            FETCH_B: begin
                if (bus.scan_enable) begin
                    state_d = DRAIN;
                end else if (bus.tile_ready_in) begin
                    row_ptr_d   = row_ptr_q + ADDR_W'(ROW_STEP);
                    remaining_d = remaining_q - CNT_W'(1);
                    addr_1_d    = row_ptr_q + ADDR_W'(ROW_STEP);
                    addr_2_d    = row_ptr_q + ADDR_W'(ROW_STEP) + ADDR_W'(1);
                    state_d     = (remaining_q == CNT_W'(1)) ? DRAIN : FETCH_A;
                end
            end
            DRAIN: begin
                // last in-flight pair returns in this cycle; finish next
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and return-path tags; async reset clears every output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            row_ptr_q    <= '0;
            remaining_q  <= '0;
            addr_1_q     <= '0;
            addr_2_q     <= '0;
            pair_valid_q <= 1'b0;
            phase_q      <= 1'b0;
            tile_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_ptr_q    <= row_ptr_d;
            remaining_q  <= remaining_d;
            addr_1_q     <= addr_1_d;
            addr_2_q     <= addr_2_d;
            pair_valid_q <= pair_valid_d;
            phase_q      <= phase_d;
            tile_last_q  <= tile_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

endmodule
